dsram_responder: RTL and testbench
==================================

Name: dsram_responder

Overview:
- Memory-side responder for the CPU data-SRAM request interface. It consumes the data_sram_en/wen/addr/wdata requests issued by the execute stage.
- Performs byte-enabled writes into an internal word array and returns load data to the memory stage after a fixed, parameterised latency.
- Flags out-of-window addresses and keeps read/write request counters for performance debug.
- Sits between the CPU core top and the testbench/SoC data port.

Parameters:
- ADDR_W, 12, word-index width; array depth = 2**ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte base address of the window; low ADDR_W+2 bits must be zero.
- READ_LAT, 1, read latency in cycles from request edge to rdata_valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_sram_en  in  1  request valid this cycle.
- data_sram_wen  in  4  byte write enables; nonzero = write, zero = read.
- data_sram_addr  in  32  byte address; word aligned by the initiator, bits [1:0] ignored.
- data_sram_wdata  in  32  write data, byte lanes already replicated by the initiator.
- data_sram_rdata  out  32  read data.
- rdata_valid  out  1  one-cycle pulse marking the response to a read.
- addr_err  out  1  pulses together with rdata_valid when that read was out of window; also pulses READ_LAT cycles after an out-of-window write.
- rd_cnt  out  32  accepted read requests, wraps modulo 2**32.
- wr_cnt  out  32  accepted write requests (including suppressed ones), wraps modulo 2**32.

Behaviour:
- No backpressure. Every cycle with data_sram_en=1 is accepted; back-to-back requests every cycle are legal.
- In-window test: data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]. Word index = data_sram_addr[ADDR_W+1:2].
- Write (en=1, wen!=0, in window): for each i, byte lane i of the word is updated from wdata[8i+7:8i] at the clock edge; lanes with wen[i]=0 are unchanged. wr_cnt increments.
- Write out of window: array is untouched and wr_cnt increments. An error token enters the latency pipe, so addr_err pulses READ_LAT cycles later with rdata_valid=0.
- Read (en=1, wen==0): the array is sampled at the request edge. The result travels a READ_LAT-deep valid/data/err pipe, so rdata_valid=1 exactly READ_LAT cycles after the request edge. For READ_LAT=1 that is the cycle after the request, the timing the MEM stage requires. rd_cnt increments.
- Read out of window: response data = 32'h0, addr_err=1 in the same cycle as rdata_valid.
- Write followed by a read of the same word in the next cycle returns the new data, because the array write completes at the write edge. A read and a write to the same word in one cycle cannot occur (single request port).
- data_sram_rdata holds its last response value while rdata_valid=0.
- en=0: no array access, no counter change, a bubble enters the pipe.
- Reset (asynchronous, any time):
  - Clears rdata_valid, addr_err, data_sram_rdata (to 0), rd_cnt, wr_cnt and all pipe valid/err bits.
  - In-flight reads are squashed and never produce rdata_valid after reset is released.
  - Array contents are not reset; they retain prior values, or X at power-up in simulation.
- A request presented while reset is asserted is ignored.
- Counter wrap: 32'hFFFF_FFFF + 1 -> 32'h0 with no flag.
- READ_LAT outside 1..4 is a configuration error. The block stops the simulation with $fatal at elaboration.

Test Plan:
- Full-word write then read: write addr 0x10, wen=4'hf, wdata=0x1234_5678; next cycle read 0x10 -> with READ_LAT=1, rdata=0x1234_5678 and rdata_valid=1 one cycle after the read; wr_cnt=1, rd_cnt=1.
- Byte merge: word 0x20 = 0xAABB_CCDD; write wen=4'b0100, wdata=0x1111_1111 -> reading 0x20 returns 0xAA11_CCDD. Then write wen=4'b0011, wdata=0x5566_5566 -> read returns 0xAA11_5566.
- Out of window, BASE_ADDR=0, ADDR_W=12: read 0x0000_4000 -> rdata=0, rdata_valid=1, addr_err=1. Write to 0x0000_4000 leaves word 0 unchanged and gives addr_err=1, rdata_valid=0 after READ_LAT cycles.
- Pipelined reads with READ_LAT=3: reads to 0x0, 0x4, 0x8 in consecutive cycles -> three consecutive rdata_valid pulses starting 3 cycles after the first request, in request order. Include a single en=0 bubble mid-stream -> a one-cycle gap in rdata_valid at the matching position.
- Reset mid-flight with READ_LAT=3: issue a read, assert reset one cycle later for 2 cycles -> rdata_valid stays 0 throughout and after release, counters are 0, and a previously written word is still readable with its value.
- Counter wrap: force wr_cnt to 32'hFFFF_FFFF via a hierarchical deposit, then issue one write -> wr_cnt = 32'h0.

Source files
------------

// File: rtl/dsram_responder.sv
// dsram_responder: memory-side responder for the CPU data-SRAM port.
// Byte-enabled writes go into an internal word array. Reads sample the array
// at the request edge and return through a READ_LAT-deep valid/err/data pipe.
// Out-of-window accesses raise addr_err. Read and write requests are counted.
module dsram_responder #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LAST  = READ_LAT - 1;

    generate
        if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
            $fatal(1, "dsram_responder: READ_LAT=%0d is outside 1..4", READ_LAT);
        end
        if (BASE_ADDR[ADDR_W+1:0] != '0) begin : g_bad_base
            $fatal(1, "dsram_responder: BASE_ADDR low ADDR_W+2 bits must be zero");
        end
    endgenerate

    logic [31:0]       mem [DEPTH];
    logic              req_en;
    logic              is_read;
    logic              is_write;
    logic              in_window;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       read_result;
    logic              vld_p  [READ_LAT];
    logic              err_p  [READ_LAT];
    logic [31:0]       data_p [READ_LAT];
    logic              vld_in  [READ_LAT];
    logic [31:0]       data_in [READ_LAT];
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;
    logic              unused_addr_lsb;

    // Address bits [1:0] are ignored: the initiator guarantees word alignment.
    assign unused_addr_lsb = ^data_sram_addr[1:0];

    // Decode the request; requests seen while reset is high are dropped.
    always_comb begin
        req_en      = data_sram_en && !reset;
        is_read     = req_en && (data_sram_wen == 4'b0000);
        is_write    = req_en && (data_sram_wen != 4'b0000);
        in_window   = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
        word_idx    = data_sram_addr[ADDR_W+1:2];
        read_result = in_window ? mem[word_idx] : 32'h0;
    end

    // Feed each pipe stage from the request (stage 0) or the previous stage.
    always_comb begin
        vld_in[0]  = is_read;
        data_in[0] = read_result;
        for (int i = 1; i < READ_LAT; i++) begin
            vld_in[i]  = vld_p[i-1];
            data_in[i] = data_p[i-1];
        end
    end

    // Latency pipe; the last data stage is the output and only loads on a valid response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LAT; i++) begin
                vld_p[i]  <= 1'b0;
                err_p[i]  <= 1'b0;
                data_p[i] <= 32'h0;
            end
        end else begin
            err_p[0] <= req_en && !in_window;
            for (int i = 1; i < READ_LAT; i++) begin
                err_p[i] <= err_p[i-1];
            end
            for (int i = 0; i < READ_LAT; i++) begin
                vld_p[i] <= vld_in[i];
                if (i != LAST || vld_in[i]) begin
                    data_p[i] <= data_in[i];
                end
            end
        end
    end

    // Byte-enabled array write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (is_write && in_window) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request counters; suppressed out-of-window writes still count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= 32'h0;
            wr_count <= 32'h0;
        end else begin
            if (is_read) begin
                rd_count <= rd_count + 32'h1;
            end
            if (is_write) begin
                wr_count <= wr_count + 32'h1;
            end
        end
    end

    assign data_sram_rdata = data_p[LAST];
    assign rdata_valid     = vld_p[LAST];
    assign addr_err        = err_p[LAST];
    assign rd_cnt          = rd_count;
    assign wr_cnt          = wr_count;

endmodule

// File: tb/tb_dsram_responder.sv
// tb_dsram_responder: drives two responders (READ_LAT=1 and READ_LAT=3) with
// the same request stream and compares both against a behavioural model.
module tb_dsram_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic [31:0] rdata1, rd1, wr1, rdata3, rd3, wr3;
    logic        valid1, err1, valid3, err3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dsram_responder #(.ADDR_W(12), .BASE_ADDR(32'h0), .READ_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata1),
        .rdata_valid(valid1), .addr_err(err1), .rd_cnt(rd1), .wr_cnt(wr1));

    dsram_responder #(.ADDR_W(12), .BASE_ADDR(32'h0), .READ_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata3),
        .rdata_valid(valid3), .addr_err(err3), .rd_cnt(rd3), .wr_cnt(wr3));

    // ---------------- behavioural model ----------------
    // Responses are scheduled by absolute edge number: a read sampled at edge n
    // is visible after edge n+LAT-1. Index 0 models LAT=1, index 1 models LAT=3.
    logic [31:0] mmem [4096];
    logic        sv [2][16];
    logic        se [2][16];
    logic [31:0] sd [2][16];
    logic        ev [2];
    logic        ee [2];
    logic [31:0] ed [2];
    logic [31:0] mrd [2];
    logic [31:0] mwr [2];
    int          edge_n;
    int          preset_req = 0;
    int          preset_seen = 0;

    always @(posedge clk or posedge reset) begin : model
        int   lat;
        int   slot;
        logic inwin;
        if (reset) begin
            for (int j = 0; j < 2; j++) begin
                ev[j] = 1'b0; ee[j] = 1'b0; ed[j] = 32'h0; mrd[j] = 32'h0; mwr[j] = 32'h0;
                for (int s = 0; s < 16; s++) begin
                    sv[j][s] = 1'b0; se[j][s] = 1'b0; sd[j][s] = 32'h0;
                end
            end
            edge_n = 0;
        end else begin
            if (preset_seen != preset_req) begin
                mwr[0] = 32'hFFFF_FFFF;
                mwr[1] = 32'hFFFF_FFFF;
                preset_seen = preset_req;
            end
            edge_n = edge_n + 1;
            inwin  = (addr[31:14] == 18'h0);
            for (int j = 0; j < 2; j++) begin
                lat  = (j == 0) ? 1 : 3;
                slot = (edge_n + lat - 1) % 16;
                if (en) begin
                    if (wen == 4'h0) begin
                        mrd[j] = mrd[j] + 32'h1;
                        sv[j][slot] = 1'b1;
                        se[j][slot] = !inwin;
                        sd[j][slot] = inwin ? mmem[addr[13:2]] : 32'h0;
                    end else begin
                        mwr[j] = mwr[j] + 32'h1;
                        if (!inwin) se[j][slot] = 1'b1;
                    end
                end
                ev[j] = sv[j][edge_n % 16];
                ee[j] = se[j][edge_n % 16];
                if (ev[j]) ed[j] = sd[j][edge_n % 16];
                sv[j][edge_n % 16] = 1'b0;
                se[j][edge_n % 16] = 1'b0;
            end
            if (en && wen != 4'h0 && inwin) begin
                for (int b = 0; b < 4; b++)
                    if (wen[b]) mmem[addr[13:2]][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    wire [97:0] got1 = {valid1, err1, rdata1, rd1, wr1};
    wire [97:0] got3 = {valid3, err3, rdata3, rd3, wr3};
    wire [97:0] exp1 = {ev[0], ee[0], ed[0], mrd[0], mwr[0]};
    wire [97:0] exp3 = {ev[1], ee[1], ed[1], mrd[1], mwr[1]};

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b1, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (got1 !== 98'h0) begin
                n_fail++; $display("FAIL reset_hold lat1 got %h want 0", got1);
            end
            n_checks++;
            if (got3 !== 98'h0) begin
                n_fail++; $display("FAIL reset_hold lat3 got %h want 0", got3);
            end
        end
        reset = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (got1 !== exp1 || got3 !== 98'h0) begin
                n_fail++; $display("FAIL reset_release got %h/%h want %h/0", got1, got3, exp1);
            end
        end
    endtask

    task automatic test_prefill();
        for (int w = 0; w < 64; w++) begin
            drive(1'b1, 4'hF, w * 4, $urandom);
            tick();
            n_checks++;
            if (got1 !== exp1 || got3 !== exp3) begin
                n_fail++; $display("FAIL prefill got %h/%h want %h/%h", got1, got3, exp1, exp3);
            end
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) tick();
    endtask

    task automatic test_full_word();
        do_reset(2);
        drive(1'b1, 4'hF, 32'h10, 32'h1234_5678);
        tick();
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        n_checks++;
        if ({valid1, rdata1, wr1, rd1} !== {1'b1, 32'h1234_5678, 32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL full_word lat1 v=%b d=%h wr=%0d rd=%0d want v=1 d=12345678 wr=1 rd=1",
                     valid1, rdata1, wr1, rd1);
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (got1 !== exp1 || got3 !== exp3) begin
                n_fail++; $display("FAIL full_word_model got %h/%h want %h/%h", got1, got3, exp1, exp3);
            end
            if (k == 1) begin
                n_checks++;
                if ({valid3, rdata3} !== {1'b1, 32'h1234_5678}) begin
                    n_fail++; $display("FAIL full_word lat3 v=%b d=%h want v=1 d=12345678", valid3, rdata3);
                end
            end
        end
    endtask

    task automatic test_byte_merge();
        logic [3:0]  t_wen [5] = '{4'hF, 4'b0100, 4'h0, 4'b0011, 4'h0};
        logic [31:0] t_dat [5] = '{32'hAABB_CCDD, 32'h1111_1111, 32'h0, 32'h5566_5566, 32'h0};
        logic [31:0] t_exp [5] = '{32'h0, 32'h0, 32'hAA11_CCDD, 32'h0, 32'hAA11_5566};
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, t_wen[k], 32'h20, t_dat[k]);
            tick();
            n_checks++;
            if (got1 !== exp1 || got3 !== exp3) begin
                n_fail++; $display("FAIL byte_merge_model got %h/%h want %h/%h", got1, got3, exp1, exp3);
            end
            if (t_wen[k] == 4'h0) begin
                n_checks++;
                if ({valid1, rdata1} !== {1'b1, t_exp[k]}) begin
                    n_fail++; $display("FAIL byte_merge v=%b d=%h want v=1 d=%h", valid1, rdata1, t_exp[k]);
                end
            end
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) tick();
    endtask

    task automatic test_out_of_window();
        logic [31:0] w0;
        drive(1'b1, 4'h0, 32'h0000_4000, 32'h0);
        tick();
        n_checks++;
        if ({valid1, err1, rdata1} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL oow_read v=%b e=%b d=%h want v=1 e=1 d=0", valid1, err1, rdata1);
        end
        w0 = mmem[0];
        drive(1'b1, 4'hF, 32'h0000_4000, 32'hDEAD_BEEF);
        tick();
        n_checks++;
        if ({valid1, err1} !== 2'b01) begin
            n_fail++; $display("FAIL oow_write v=%b e=%b want v=0 e=1", valid1, err1);
        end
        drive(1'b1, 4'h0, 32'h0, 32'h0);
        tick();
        n_checks++;
        if ({valid1, err1, rdata1} !== {1'b1, 1'b0, w0}) begin
            n_fail++; $display("FAIL oow_word0 v=%b e=%b d=%h want v=1 e=0 d=%h", valid1, err1, rdata1, w0);
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (got1 !== exp1 || got3 !== exp3) begin
                n_fail++; $display("FAIL oow_model got %h/%h want %h/%h", got1, got3, exp1, exp3);
            end
        end
    endtask

    task automatic test_pipelined();
        logic         t_en [10] = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
        logic [31:0]  t_ad [10] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'hC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [9:0]   pattern = '0;
        logic [127:0] seen = '0;
        logic [127:0] want;
        want = {mmem[0], mmem[1], mmem[2], mmem[3]};
        for (int k = 0; k < 10; k++) begin
            drive(t_en[k], 4'h0, t_ad[k], 32'h0);
            tick();
            pattern[k] = valid3;
            if (valid3) seen = {seen[95:0], rdata3};
            n_checks++;
            if (got1 !== exp1 || got3 !== exp3) begin
                n_fail++; $display("FAIL pipelined_model got %h/%h want %h/%h", got1, got3, exp1, exp3);
            end
        end
        n_checks++;
        if (pattern !== 10'h05C) begin
            n_fail++; $display("FAIL pipelined_pattern got %b want 0001011100", pattern);
        end
        n_checks++;
        if (seen !== want) begin
            n_fail++; $display("FAIL pipelined_order got %h want %h", seen, want);
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 4'hF, 32'h30, 32'hCAFE_F00D);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) tick();
        drive(1'b1, 4'h0, 32'h30, 32'h0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if ({valid3, rd3, wr3} !== {1'b0, 32'h0, 32'h0}) begin
                n_fail++; $display("FAIL midflight_hold v=%b rd=%0d wr=%0d want 0", valid3, rd3, wr3);
            end
        end
        reset = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({valid3, valid1, rd3, wr3, rd1, wr1} !== 130'h0 || got3 !== exp3) begin
                n_fail++;
                $display("FAIL midflight_after v3=%b v1=%b rd3=%0d wr3=%0d rd1=%0d wr1=%0d want all 0",
                         valid3, valid1, rd3, wr3, rd1, wr1);
            end
        end
        drive(1'b1, 4'h0, 32'h30, 32'h0);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 1) begin
                n_checks++;
                if ({valid3, rdata3} !== {1'b1, 32'hCAFE_F00D}) begin
                    n_fail++; $display("FAIL midflight_retain v=%b d=%h want v=1 d=cafef00d", valid3, rdata3);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(0, 1) == 1) ? (32'h0000_4000 + ($urandom_range(0, 63) << 2))
                                                 : 32'hFFFF_FFFC;
            else
                a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15)),
                  a, $urandom);
            tick();
            n_checks++;
            if (got1 !== exp1) begin
                n_fail++; $display("FAIL random lat1 cycle %0d got %h want %h", k, got1, exp1);
            end
            n_checks++;
            if (got3 !== exp3) begin
                n_fail++; $display("FAIL random lat3 cycle %0d got %h want %h", k, got3, exp3);
            end
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) tick();
    endtask

    task automatic test_counter_wrap();
        force u_lat1.wr_count = 32'hFFFF_FFFF;
        force u_lat3.wr_count = 32'hFFFF_FFFF;
        #1;
        release u_lat1.wr_count;
        release u_lat3.wr_count;
        preset_req = preset_req + 1;
        drive(1'b1, 4'hF, 32'h40, 32'h0BAD_F00D);
        tick();
        n_checks++;
        if ({wr1, wr3} !== 64'h0) begin
            n_fail++; $display("FAIL counter_wrap wr1=%h wr3=%h want 0/0", wr1, wr3);
        end
        n_checks++;
        if (got1 !== exp1 || got3 !== exp3) begin
            n_fail++; $display("FAIL counter_wrap_model got %h/%h want %h/%h", got1, got3, exp1, exp3);
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_full_word();
        test_byte_merge();
        test_out_of_window();
        test_pipelined();
        test_reset_midflight();
        test_random();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
